expr_result_unpacker: RTL and testbench



---
 rtl/expr_result_unpacker.sv | 111 +++++++++++
 tb/tb_expr_result_unpacker.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/expr_result_unpacker.sv
// expr_result_unpacker: serialises a 90-bit packed 4/5/6-bit field word into 18 extended fields with XOR checksum
module expr_result_unpacker #(
    parameter int OUT_W  = 8,
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [89:0]       in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_field,
    output logic [4:0]        out_idx,
    output logic              out_signed,
    output logic              out_last,
    output logic [OUT_W-1:0]  out_xsum,
    output logic [FCNT_W-1:0] frame_count
);
    typedef enum logic {IDLE, EMIT} state_t;
    state_t              r_state, w_next;
    logic [89:0]         r_hold;
    logic [4:0]          r_idx;
    logic [OUT_W-1:0]    r_field, r_acc;
    logic                r_signed, r_last;
    logic [FCNT_W-1:0]   r_fcnt;
    logic                w_accept, w_fire, w_end;
    logic [4:0]          w_nidx;

    function automatic logic [2:0] kof(input logic [4:0] i);
        return 3'(i - (i >= 5'd12 ? 5'd12 : i >= 5'd6 ? 5'd6 : 5'd0));
    endfunction

    // Field i occupies the 4..6 bits starting (offset) bits below bit 89; pull the top 6 bits
    // from there, drop the surplus low bits, then sign-extend if the field is in a signed slot.
    function automatic logic [OUT_W-1:0] ext(input logic [89:0] w, input logic [4:0] i);
        logic [2:0]       k;
        logic [6:0]       off;
        logic [2:0]       wd;
        logic [5:0]       raw;
        logic [OUT_W-1:0] v;
        k   = kof(i);
        off = (i >= 5'd12 ? 7'd60 : i >= 5'd6 ? 7'd30 : 7'd0)
            + (k == 3'd0 ? 7'd0 : k == 3'd1 ? 7'd4 : k == 3'd2 ? 7'd9 :
               k == 3'd3 ? 7'd15 : k == 3'd4 ? 7'd19 : 7'd24);
        wd  = (k == 3'd0 || k == 3'd3) ? 3'd4 : (k == 3'd1 || k == 3'd4) ? 3'd5 : 3'd6;
        raw = 6'(w >> (7'd84 - off)) >> (3'd6 - wd);
        v   = OUT_W'(raw);
        return (k >= 3'd3 && raw[wd - 3'd1]) ? v | ({OUT_W{1'b1}} << wd) : v;
    endfunction

    assign w_accept = in_valid & in_ready;
    assign w_fire   = out_valid & out_ready;
    assign w_end    = w_fire & r_last;
    assign w_nidx   = r_idx + 5'd1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state: a new word always (re)enters EMIT; finishing the last field without one returns to IDLE
    always_comb begin
        w_next = w_accept ? EMIT : w_end ? IDLE : r_state;
    end

    // Handshake outputs; in EMIT a new word is taken only as the last field leaves, giving bubble-free frames
    always_comb begin
        out_valid = r_state == EMIT;
        in_ready  = r_state == IDLE || (r_last && out_ready);
    end

    // Hold register, field index, presented field, checksum accumulator and decoded flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold   <= '0;
            r_idx    <= '0;
            r_field  <= '0;
            r_acc    <= '0;
            r_signed <= 1'b0;
            r_last   <= 1'b0;
        end else if (w_accept) begin
            r_hold   <= in_data;
            r_idx    <= '0;
            r_field  <= ext(in_data, 5'd0);
            r_acc    <= '0;
            r_signed <= 1'b0;
            r_last   <= 1'b0;
        end else if (w_fire && !r_last) begin
            r_idx    <= w_nidx;
            r_field  <= ext(r_hold, w_nidx);
            r_acc    <= r_acc ^ r_field;
            r_signed <= kof(w_nidx) >= 3'd3;
            r_last   <= w_nidx == 5'd17;
        end
    end

    // Frame counter counts words whose last field was handed off
    always_ff @(posedge clk) begin
        if (rst)        r_fcnt <= '0;
        else if (w_end) r_fcnt <= r_fcnt + 1'b1;
    end

    assign out_field   = r_field;
    assign out_idx     = r_idx;
    assign out_signed  = r_signed;
    assign out_last    = r_last;
    assign out_xsum    = r_acc ^ r_field;
    assign frame_count = r_fcnt;
endmodule

// File: tb/tb_expr_result_unpacker.sv
// tb_expr_result_unpacker: table vectors plus scoreboard checking of the field unpacker
module tb_expr_result_unpacker;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, out_signed, out_last;
    logic [89:0] in_data;
    logic [7:0]  out_field, out_xsum;
    logic [4:0]  out_idx;
    logic [15:0] frame_count;

    expr_result_unpacker #(.OUT_W(8), .FCNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_field(out_field), .out_idx(out_idx),
        .out_signed(out_signed), .out_last(out_last), .out_xsum(out_xsum), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] f;
        logic [4:0] idx;
        logic       sg;
        logic       last;
        logic [7:0] xs;
    } exp_t;

    typedef struct {
        logic [89:0] d;
        logic [7:0]  xs;
        logic [4:0]  pidx;
        logic [7:0]  pval;
    } vec_t;

    exp_t       sb[$];
    int         errors = 0, checks = 0;
    int         exp_frames = 0, vcyc = 0, ov_acc = 0;
    logic       xs_en = 1'b0;
    logic [7:0] xs_val = '0, pval = '0;
    logic [4:0] pidx = 5'd31;
    logic       last_acc, last_fire;
    logic [4:0] last_idx;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic logic [7:0] mfield(input logic [89:0] d, input int i);
        int offs[6] = '{0, 4, 9, 15, 19, 24};
        int wds[6]  = '{4, 5, 6, 4, 5, 6};
        int k, w, msb;
        logic [7:0] v;
        k = i % 6;
        w = wds[k];
        msb = 89 - 30 * (i / 6) - offs[k];
        v = '0;
        for (int b = 0; b < 8; b++) begin
            if (b < w) v[b] = d[msb - w + 1 + b];
            else if (k >= 3) v[b] = d[msb];
        end
        return v;
    endfunction

    task automatic push_word(input logic [89:0] d);
        logic [7:0] f[18];
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < 18; i++) begin
            f[i] = mfield(d, i);
            x ^= f[i];
        end
        for (int i = 0; i < 18; i++)
            sb.push_back('{f[i], 5'(i), (i % 6) >= 3, i == 17, xs_en ? xs_val : x});
    endtask

    task automatic step(input logic v, input logic [89:0] d, input logic r, input logic rs);
        exp_t e;
        @(negedge clk);
        in_valid = v; in_data = d; out_ready = r; rst = rs;
        #2;
        last_acc = in_valid && in_ready;
        last_fire = out_valid && out_ready;
        last_idx = out_idx;
        if (!rs) begin
            if (last_acc) begin
                push_word(in_data);
                if (out_valid) ov_acc++;
            end
            if (out_valid) begin
                vcyc++;
                if (sb.size() == 0) chk("unexpected_output", 1, 0);
                else begin
                    e = sb[0];
                    if (out_ready) void'(sb.pop_front());
                    chk("out_idx", out_idx, e.idx);
                    chk("out_field", out_field, e.f);
                    chk("out_signed", out_signed, e.sg);
                    chk("out_last", out_last, e.last);
                    if (e.last) chk("out_xsum", out_xsum, e.xs);
                    if (!out_ready || !e.last) chk("in_ready_busy", in_ready, 0);
                    if (out_ready && out_idx == pidx) chk("table_field", out_field, pval);
                    if (out_ready && e.last) exp_frames++;
                end
            end
        end
    endtask

    task automatic run(input logic [89:0] wa, input logic [89:0] wb, input int nw, input int mode);
        int sent, t;
        logic r;
        sent = 0; t = 0; vcyc = 0;
        while ((sent < nw || sb.size() > 0) && t < 300) begin
            r = !(mode == 1 && (vcyc == 1 || vcyc == 2));
            step(sent < nw, sent == 0 ? wa : wb, r, 1'b0);
            if (last_acc) sent++;
            t++;
        end
        if (t >= 300) begin
            chk("timeout", 1, 0);
            sb.delete();
        end
        step(1'b0, '0, 1'b1, 1'b0);
        chk("idle_after_run", out_valid, 0);
        chk("frame_count", frame_count, exp_frames);
    endtask

    initial begin
        vec_t tv[4];
        logic found;
        tv[0] = '{{90{1'b1}}, 8'hD0, 5'd0, 8'h0F};
        tv[1] = '{90'd1 << 65, 8'hE0, 5'd5, 8'hE0};
        tv[2] = '{(90'd7 << 71) | (90'd16 << 66), 8'hF7, 5'd4, 8'hF0};
        tv[3] = '{90'd0, 8'h00, 5'd17, 8'h00};
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_field", out_field, 0);
        chk("rst_out_signed", out_signed, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_xsum", out_xsum, 0);
        chk("rst_frame_count", frame_count, 0);
        for (int v = 0; v < 4; v++) begin
            xs_en = 1'b1; xs_val = tv[v].xs; pidx = tv[v].pidx; pval = tv[v].pval;
            run(tv[v].d, '0, 1, 0);
        end
        xs_en = 1'b1; xs_val = 8'hD0; pidx = 5'd3; pval = 8'hFF;
        run(tv[0].d, '0, 1, 1);
        xs_en = 1'b0; pidx = 5'd31; ov_acc = 0;
        run(tv[2].d, tv[1].d, 2, 0);
        chk("b2b_valid_cycles", vcyc, 36);
        chk("b2b_overlap_accepts", ov_acc, 1);
        for (int n = 0; n < 3; n++) run(90'({$urandom, $urandom, $urandom}), '0, 1, 0);
        step(1'b1, tv[0].d, 1'b1, 1'b0);
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            found = last_fire && last_idx == 5'd8;
        end
        chk("reach_idx9", found, 1);
        step(1'b0, '0, 1'b1, 1'b1);
        sb.delete();
        exp_frames = 0;
        step(1'b0, '0, 1'b1, 1'b0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_frame_count", frame_count, 0);
        chk("midrst_out_idx", out_idx, 0);
        xs_en = 1'b1; xs_val = 8'hD0; pidx = 5'd2; pval = 8'h3F;
        run(tv[0].d, '0, 1, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
